// File: rtl/pixel_operator_pipe.sv
// Two-stage streaming point operator (pass/sub/add/threshold/invert/window) per channel,
// with frame-synchronous config. Optional saturation statistics when FRAME_STATS_EN is defined.
module pixel_operator_pipe #(
  parameter int PIX_W  = 12,
  parameter int NUM_CH = 1,
  parameter int MODE_W = 3
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [NUM_CH*PIX_W-1:0] s_data,
  input  logic                    s_sof,
  input  logic                    s_eof,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [NUM_CH*PIX_W-1:0] m_data,
  output logic                    m_sof,
  output logic                    m_eof,
  input  logic                    cfg_wr,
  input  logic [MODE_W-1:0]       cfg_mode,
  input  logic [PIX_W-1:0]        cfg_value,
  input  logic [PIX_W-1:0]        cfg_thresh,
  output logic                    cfg_pending,
  output logic [31:0]             stat_sat_cnt,
  output logic                    stat_valid
);

  localparam logic [PIX_W-1:0] MAX = {PIX_W{1'b1}};

  function automatic logic [PIX_W-1:0] f_point_op(input logic [MODE_W-1:0] mode,
                                                  input logic [PIX_W-1:0] x,
                                                  input logic [PIX_W-1:0] v,
                                                  input logic [PIX_W-1:0] t);
    logic [PIX_W:0] sum;
    sum = {1'b0, x} + {1'b0, v};
    case (mode)
      MODE_W'(32'd1): return (x < v) ? '0 : x - v;
      MODE_W'(32'd2): return sum[PIX_W] ? MAX : sum[PIX_W-1:0];
      MODE_W'(32'd3): return (x > t) ? MAX : '0;
      MODE_W'(32'd4): return MAX - x;
      MODE_W'(32'd5): return (x >= v && x <= t) ? x : '0;
      default:        return x;
    endcase
  endfunction

  logic                    r_s1_valid, r_s1_sof, r_s1_eof;
  logic [NUM_CH*PIX_W-1:0] r_s1_data;
  logic                    r_m_valid, r_m_sof, r_m_eof;
  logic [NUM_CH*PIX_W-1:0] r_m_data;
  logic [MODE_W-1:0]       r_act_mode, r_sh_mode;
  logic [PIX_W-1:0]        r_act_value, r_act_thresh, r_sh_value, r_sh_thresh;
  logic                    r_pending;

  logic                    w_adv, w_acc, w_load;
  logic [MODE_W-1:0]       w_mode;
  logic [PIX_W-1:0]        w_value, w_thresh;
  logic [NUM_CH*PIX_W-1:0] w_s1_data;

  assign w_adv       = !r_m_valid || m_ready;
  assign w_acc       = s_valid && w_adv;
  assign w_load      = w_acc && s_sof && (r_pending || cfg_wr);
  assign s_ready     = w_adv;
  assign m_valid     = r_m_valid;
  assign m_data      = r_m_data;
  assign m_sof       = r_m_sof;
  assign m_eof       = r_m_eof;
  assign cfg_pending = r_pending;

  // Config seen by the incoming beat: a sof beat may switch to the new config in the same cycle.
  always_comb begin
    w_mode   = r_act_mode;
    w_value  = r_act_value;
    w_thresh = r_act_thresh;
    if (w_load && cfg_wr) begin
      w_mode   = cfg_mode;
      w_value  = cfg_value;
      w_thresh = cfg_thresh;
    end else if (w_load) begin
      w_mode   = r_sh_mode;
      w_value  = r_sh_value;
      w_thresh = r_sh_thresh;
    end else begin
      w_mode   = r_act_mode;
      w_value  = r_act_value;
      w_thresh = r_act_thresh;
    end
  end

  // Apply the operation to each channel independently.
  always_comb begin
    w_s1_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_s1_data[k*PIX_W +: PIX_W] = f_point_op(w_mode, s_data[k*PIX_W +: PIX_W], w_value, w_thresh);
    end
  end

  // Shadow and active config registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_act_mode   <= '0;
      r_act_value  <= '0;
      r_act_thresh <= '0;
      r_sh_mode    <= '0;
      r_sh_value   <= '0;
      r_sh_thresh  <= '0;
      r_pending    <= 1'b0;
    end else begin
      if (cfg_wr) begin
        r_sh_mode   <= cfg_mode;
        r_sh_value  <= cfg_value;
        r_sh_thresh <= cfg_thresh;
      end
      if (w_load) begin
        r_act_mode   <= w_mode;
        r_act_value  <= w_value;
        r_act_thresh <= w_thresh;
        r_pending    <= 1'b0;
      end else if (cfg_wr) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Compute stage and output register; both shift together on advance.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_sof   <= 1'b0;
      r_s1_eof   <= 1'b0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_m_sof    <= 1'b0;
      r_m_eof    <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= s_valid;
      r_s1_data  <= w_s1_data;
      r_s1_sof   <= s_valid && s_sof;
      r_s1_eof   <= s_valid && s_eof;
      r_m_valid  <= r_s1_valid;
      r_m_data   <= r_s1_data;
      r_m_sof    <= r_s1_sof;
      r_m_eof    <= r_s1_eof;
    end
  end

`ifdef FRAME_STATS_EN
  localparam int CNT_W = $clog2(NUM_CH + 1);

  function automatic logic f_clamped(input logic [MODE_W-1:0] mode,
                                     input logic [PIX_W-1:0] x,
                                     input logic [PIX_W-1:0] v);
    logic [PIX_W:0] sum;
    sum = {1'b0, x} + {1'b0, v};
    case (mode)
      MODE_W'(32'd1): return x < v;
      MODE_W'(32'd2): return sum[PIX_W];
      default:        return 1'b0;
    endcase
  endfunction

  logic [CNT_W-1:0] w_s1_sat, r_s1_sat, r_m_sat;
  logic [32:0]      w_acc_sum;
  logic [31:0]      w_acc_next, r_acc, r_stat_cnt;
  logic             w_out_acc, r_stat_valid;

  assign w_out_acc    = r_m_valid && m_ready;
  assign stat_sat_cnt = r_stat_cnt;
  assign stat_valid   = r_stat_valid;

  // Number of clamped channels in the incoming beat.
  always_comb begin
    w_s1_sat = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_s1_sat = w_s1_sat + CNT_W'(f_clamped(w_mode, s_data[k*PIX_W +: PIX_W], w_value));
    end
  end

  // A sof beat restarts the running count; the sum saturates at all-ones.
  always_comb begin
    w_acc_sum  = (r_m_sof ? 33'd0 : {1'b0, r_acc}) + {{(33-CNT_W){1'b0}}, r_m_sat};
    w_acc_next = w_acc_sum[32] ? 32'hFFFF_FFFF : w_acc_sum[31:0];
  end

  // Statistics pipeline, running counter and per-frame result latch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_sat     <= '0;
      r_m_sat      <= '0;
      r_acc        <= 32'd0;
      r_stat_cnt   <= 32'd0;
      r_stat_valid <= 1'b0;
    end else begin
      if (w_adv) begin
        r_s1_sat <= w_s1_sat;
        r_m_sat  <= r_s1_sat;
      end
      if (w_out_acc) begin
        r_acc <= w_acc_next;
      end
      r_stat_valid <= w_out_acc && r_m_eof;
      if (w_out_acc && r_m_eof) begin
        r_stat_cnt <= w_acc_next;
      end
    end
  end
`else
  assign stat_sat_cnt = 32'd0;
  assign stat_valid   = 1'b0;
`endif

endmodule
